// File: rtl/conv33_stream.sv
// Streaming 3x3 convolution: builds the window from a raster stream with two line buffers,
// applies a fixed or runtime-loaded kernel and emits saturated pixels over valid/ready.
module conv33_stream #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_LEN    = 64,
  parameter int COEF_WIDTH  = 6,
  parameter int ACCW        = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            mode,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  frame_err
);

  localparam int CW = $clog2(LINE_LEN);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
  localparam logic signed [ACCW-1:0] PIX_MAX = ACCW'((1 << PIXEL_WIDTH) - 1);

  typedef enum logic [2:0] {
    MODE_PASS    = 3'd0,
    MODE_SHARPEN = 3'd1,
    MODE_GAUSS   = 3'd2,
    MODE_EDGE    = 3'd3,
    MODE_CUSTOM  = 3'd4
  } mode_e;

  logic [CW-1:0] col;
  logic [1:0]    row;          // saturates at 2: only "row >= 2" matters
  mode_e         act_mode;
  logic signed [COEF_WIDTH-1:0] shd_k [9];
  logic signed [COEF_WIDTH-1:0] act_k [9];
  logic [3:0]    shd_shift, act_shift;

  logic [PIXEL_WIDTH-1:0] lb0 [LINE_LEN];  // previous line
  logic [PIXEL_WIDTH-1:0] lb1 [LINE_LEN];  // line before that
  logic [PIXEL_WIDTH-1:0] win     [9];     // index row*3+col, row 0 = oldest line
  logic [PIXEL_WIDTH-1:0] win_nxt [9];

  logic signed [ACCW-1:0] kc [9];
  logic [3:0]             sh;
  logic signed [ACCW-1:0] acc, res;
  logic [PIXEL_WIDTH-1:0] sat;
  logic accept, frame_start, win_pos;

  assign s_ready     = m_ready || !m_valid;
  assign accept      = s_valid && s_ready;
  assign frame_start = accept && (col == '0) && (row == 2'd0);
  assign win_pos     = (row == 2'd2) && (col >= CW'(2));

  // NOTE: line-buffer RAMs carry no reset so they map onto plain memory; rows 0-1 of every frame refill them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= s_data;
      lb1[col] <= lb0[col];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r*3]   = win[r*3+1];
      win_nxt[r*3+1] = win[r*3+2];
      win_nxt[r*3+2] = '0;
    end
    win_nxt[2] = lb1[col];
    win_nxt[5] = lb0[col];
    win_nxt[8] = s_data;
  end

  always_comb begin
    for (int i = 0; i < 9; i++) kc[i] = '0;
    kc[4] = ACCW'(1);
    sh    = 4'd0;
    case (act_mode)
      MODE_SHARPEN: begin
        kc[1] = ACCW'(-1); kc[3] = ACCW'(-1); kc[4] = ACCW'(5);
        kc[5] = ACCW'(-1); kc[7] = ACCW'(-1);
      end
      MODE_GAUSS: begin
        kc[0] = ACCW'(1); kc[1] = ACCW'(2); kc[2] = ACCW'(1);
        kc[3] = ACCW'(2); kc[4] = ACCW'(4); kc[5] = ACCW'(2);
        kc[6] = ACCW'(1); kc[7] = ACCW'(2); kc[8] = ACCW'(1);
        sh    = 4'd4;
      end
      MODE_EDGE: begin
        for (int i = 0; i < 9; i++) kc[i] = (i == 4) ? ACCW'(8) : ACCW'(-1);
      end
      MODE_CUSTOM: begin
        for (int i = 0; i < 9; i++)
          kc[i] = {{(ACCW-COEF_WIDTH){act_k[i][COEF_WIDTH-1]}}, act_k[i]};
        sh = act_shift;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++)
      acc = acc + kc[i] * $signed({{(ACCW-PIXEL_WIDTH){1'b0}}, win_nxt[i]});
    res = acc >>> sh;
    if (res < 0)             sat = '0;
    else if (res > PIX_MAX)  sat = '1;
    else                     sat = res[PIXEL_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= 2'd0;
      frame_err <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      frame_err <= accept && s_last && (col != COL_LAST);
      if (accept) begin
        win <= win_nxt;
        if (s_last) begin
          col <= '0;
          row <= 2'd0;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= (row == 2'd2) ? 2'd2 : row + 2'd1;
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Shadow kernel is written any time; the active copy only changes at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mode  <= MODE_PASS;
      shd_shift <= 4'd0;
      act_shift <= 4'd0;
      for (int i = 0; i < 9; i++) begin
        shd_k[i] <= (i == 4) ? COEF_WIDTH'(1) : '0;
        act_k[i] <= (i == 4) ? COEF_WIDTH'(1) : '0;
      end
    end else begin
      if (coef_we) begin
        if (coef_addr < 4'd9)       shd_k[coef_addr] <= coef_data;
        else if (coef_addr == 4'd9) shd_shift        <= coef_data[3:0];
      end
      if (frame_start) begin
        act_mode  <= (mode > 3'd4) ? MODE_PASS : mode_e'(mode);
        act_k     <= shd_k;
        act_shift <= shd_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (accept && win_pos) begin
      m_valid <= 1'b1;
      m_data  <= sat;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv33_stream.sv
// Bench for conv33_stream: directed and random frames scored against a plain-arithmetic
// per-frame convolution model with a queue of expected output pixels.
module tb_conv33_stream;
  localparam int PW = 8;
  localparam int LL = 8;
  localparam int CWD = 6;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] mode;
  logic s_valid, s_ready, s_last;
  logic [PW-1:0] s_data;
  logic m_valid, m_ready, m_last;
  logic [PW-1:0] m_data;
  logic coef_we;
  logic [3:0] coef_addr;
  logic [CWD-1:0] coef_data;
  logic frame_err;

  conv33_stream #(.PIXEL_WIDTH(PW), .LINE_LEN(LL), .COEF_WIDTH(CWD), .ACCW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] d; logic l; } out_t;
  typedef struct { logic [3:0] a; logic [CWD-1:0] d; } cw_t;

  int total = 0;
  int bad = 0;
  out_t exp_q[$];
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] ref_q[$];
  cw_t cw_q[$];
  logic [PW-1:0] pix [64];
  int sh_k [9];
  int sh_shift;
  int err_seen = 0;
  int exp_err = 0;
  int gap_en = 0, rdy_rnd = 0, stall_at = -1, chg_at = -1, abort_at = -1;
  logic [2:0] chg_mode;
  bit hold_v = 0;
  logic [PW-1:0] hold_d;
  out_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void reset_shadow();
    for (int i = 0; i < 9; i++) sh_k[i] = (i == 4) ? 1 : 0;
    sh_shift = 0;
  endfunction

  // Reference: direct 3x3 sum over the frame image for every valid window position.
  function automatic void model_frame(input int n);
    int k[9];
    int s, m, acc, p, r, c;
    m = (int'(mode) > 4) ? 0 : int'(mode);
    s = 0;
    case (m)
      1: k = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
      2: begin k = '{1, 2, 1, 2, 4, 2, 1, 2, 1}; s = 4; end
      3: k = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
      4: begin k = sh_k; s = sh_shift; end
      default: k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    endcase
    for (int i = 0; i < n; i++) begin
      r = i / LL;
      c = i % LL;
      if (r >= 2 && c >= 2) begin
        acc = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) begin
            p = int'(pix[(r - 2 + dr) * LL + c - 2 + dc]);
            acc += p * k[dr * 3 + dc];
          end
        acc = acc >>> s;
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
        exp_q.push_back('{d: PW'(acc), l: (i == n - 1)});
      end
    end
  endfunction

  task automatic apply_writes();
    cw_t w;
    while (cw_q.size() > 0) begin
      w = cw_q.pop_front();
      coef_we = 1'b1;
      coef_addr = w.a;
      coef_data = w.d;
      @(posedge clk); #1;
      if (w.a < 4'd9) sh_k[w.a] = int'($signed(w.d));
      else if (w.a == 4'd9) sh_shift = int'(w.d[3:0]);
    end
    coef_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_d);
      end
      if (frame_err) err_seen++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_out", m_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("out_data", m_data, mon_e.d);
          check("out_last", m_last, mon_e.l);
          got_q.push_back(m_data);
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic send_frame(input int n);
    int i, stall, guard, w;
    logic acc;
    bit aborted;
    i = 0; stall = 0; guard = 0; aborted = 0;
    got_q.delete();
    model_frame(n);
    while (i < n) begin
      if (i == chg_at) begin
        s_valid = 1'b0;
        mode = chg_mode;
        apply_writes();
        chg_at = -1;
      end
      if (i == abort_at) begin
        check("pre_rst_valid", m_valid, 1);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_s_ready", s_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        reset_shadow();
        abort_at = -1;
        aborted = 1;
        break;
      end
      s_valid = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = pix[i];
      s_last = (i == n - 1);
      m_ready = (stall > 0) ? 1'b0 : (rdy_rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (stall > 0) begin
        check("stall_s_ready", s_ready, 0);
        check("stall_m_valid", m_valid, 1);
      end
      @(posedge clk); #1;
      if (stall > 0) stall--;
      if (acc) begin
        if (i == stall_at) stall = 5;
        i++;
      end
      guard++;
      if (guard > 3000) begin
        check("tx_timeout", guard, 0);
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    w = 0;
    while (exp_q.size() > 0 && w < 100) begin
      m_ready = 1'b1;
      @(posedge clk); #1;
      w++;
    end
    m_ready = 1'b1;
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    if (!aborted && ((n - 1) % LL != LL - 1)) exp_err++;
    check("frame_err_cnt", err_seen, exp_err);
  endtask

  task automatic fill(input int n, input int v);
    for (int i = 0; i < n; i++) pix[i] = PW'(v);
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) pix[i] = PW'(i);
  endtask

  task automatic cmp_ref(input string tag);
    check({tag, "_cnt"}, got_q.size(), ref_q.size());
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      check(tag, got_q[i], ref_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got=0 expected=1");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    rst_n = 1'b0; mode = 3'd0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    reset_shadow();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp pass-through, 8x4
    ramp(32);
    send_frame(32);
    check("ramp_cnt", got_q.size(), 12);
    if (got_q.size() >= 12) begin
      check("ramp_first", got_q[0], 9);
      check("ramp_row1_end", got_q[5], 14);
      check("ramp_row2_start", got_q[6], 17);
      check("ramp_lastval", got_q[11], 22);
    end
    ref_q = got_q;

    // Edge: uniform, then impulse at (2,2)
    mode = 3'd3;
    fill(32, 100);
    send_frame(32);
    fill(40, 0);
    pix[2 * LL + 2] = 8'd255;
    send_frame(40);
    if (got_q.size() >= 8) begin
      check("edge_imp_centre", got_q[7], 255);
      check("edge_imp_nbr", got_q[6], 0);
    end

    // Gaussian and sharpen
    mode = 3'd2; fill(32, 16); send_frame(32);
    mode = 3'd1; fill(32, 200); send_frame(32);
    fill(40, 0);
    pix[2 * LL + 2] = 8'd255;
    send_frame(40);
    if (got_q.size() >= 8) check("sharp_imp_centre", got_q[7], 255);

    // Back-pressure mid-frame
    mode = 3'd0;
    ramp(32);
    stall_at = 20;
    send_frame(32);
    stall_at = -1;
    cmp_ref("stall_vs_ramp");

    // Mode/coef change mid-frame only affects the next frame
    chg_at = 10;
    chg_mode = 3'd3;
    for (int i = 0; i < 9; i++) cw_q.push_back('{a: 4'(i), d: CWD'(1)});
    cw_q.push_back('{a: 4'd9, d: CWD'(3)});
    ramp(32);
    send_frame(32);
    cmp_ref("chg_frame_a");
    fill(32, 8);
    send_frame(32);
    mode = 3'd4;
    send_frame(32);
    if (got_q.size() > 0) check("custom_ones", got_q[0], 9);
    for (int i = 0; i < 9; i++) cw_q.push_back('{a: 4'(i), d: (i == 4) ? CWD'(6'h3F) : CWD'(0)});
    cw_q.push_back('{a: 4'd9, d: CWD'(0)});
    cw_q.push_back('{a: 4'd12, d: CWD'(5)});
    apply_writes();
    send_frame(32);
    if (got_q.size() > 0) check("custom_neg", got_q[0], 0);

    // Short frame, then a normal one
    mode = 3'd0;
    ramp(32);
    send_frame(28);
    send_frame(32);
    cmp_ref("after_short");

    // Reset mid-frame, then a normal frame
    abort_at = 21;
    send_frame(32);
    send_frame(32);
    cmp_ref("after_reset");

    // Random frames with gaps, random back-pressure and mid-frame changes
    gap_en = 1;
    rdy_rnd = 1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 10; i++)
        cw_q.push_back('{a: 4'(i), d: (i == 9) ? CWD'($urandom_range(0, 7)) : CWD'($urandom_range(0, 63))});
      apply_writes();
      mode = 3'($urandom_range(0, 7));
      h = $urandom_range(3, 6);
      for (int i = 0; i < h * LL; i++) pix[i] = PW'($urandom_range(0, 255));
      if (f % 3 == 1) begin
        chg_at = $urandom_range(1, h * LL - 1);
        chg_mode = 3'($urandom_range(0, 7));
        cw_q.push_back('{a: 4'($urandom_range(0, 9)), d: CWD'($urandom_range(0, 63))});
      end
      send_frame((f == 5) ? h * LL - 3 : h * LL);
      chg_at = -1;
      cw_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
